// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port synchronous Memory between an instruction-fetch
//   port (read only) and a data port (read/write). Each granted request
//   runs a fixed three-state sequence IDLE -> ACCESS -> RESP -> IDLE, and
//   the requester's done pulse is issued in the cycle after RESP.
//
//   Timing of one transaction (grant taken at posedge N):
//     cycle after N   : ACCESS, mem_read or mem_write high for this cycle
//     cycle after N+1 : RESP, Memory presents the registered mem_data
//     cycle after N+2 : IDLE, done pulse high, rdata valid (reads)
//
//   The cycle in which a done pulse is high is a turnaround cycle: no new
//   grant is taken in it. This keeps a requester that still holds its
//   request from being re-granted on a stale request, and it lets a tie
//   that persists across back-to-back transactions be resolved by the tie
//   policy instead of by whichever port happens to be done.
//
// Configuration:
//   MEM_ARB_RR_EN  defined   : round-robin on a tie (grant the port not
//                              granted last; last-grant updated on every
//                              grant, reset value = data port).
//                  undefined : fixed priority, the data port wins a tie.
//
// Parameters:
//   AW  address width (word index, passed through unchanged)
//   DW  data width
//
// Ports:
//   clk        single clock, all state changes on posedge
//   rst_n      synchronous active-low reset
//   i_req      fetch request, held until i_done
//   i_addr     fetch address
//   i_done     one-cycle pulse, fetch complete (rdata valid)
//   d_req      data request, held until d_done
//   d_we       data write enable (1 = write)
//   d_addr     data address
//   d_wdata    data write value
//   d_done     one-cycle pulse, data access complete
//   rdata      read data shared by both ports
//   busy       high whenever the arbiter is not in IDLE
//   mem_addr   Memory address
//   mem_wdata  Memory write data
//   mem_read   Memory read strobe (ACCESS cycle only)
//   mem_write  Memory write strobe (ACCESS cycle only)
//   mem_data   Memory read data, registered one edge after mem_read
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_done,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_data
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_t;

   state_t          state_r;
   logic [AW-1:0]   addr_r;
   logic [DW-1:0]   wdata_r;
   logic            we_r;
   logic            port_d_r;      // 1 = data port owns the transaction
   logic            i_done_r;
   logic            d_done_r;
   logic [DW-1:0]   rdata_r;
   logic            busy_r;
   logic            mem_read_r;
   logic            mem_write_r;
`ifdef MEM_ARB_RR_EN
   logic            last_d_r;      // 1 = data port was granted last
`endif

   logic            turnaround_s;
   logic            i_elig_s;
   logic            d_elig_s;
   logic            grant_v_s;
   logic            grant_d_s;
   logic [AW-1:0]   sel_addr_s;
   logic [DW-1:0]   sel_wdata_s;
   logic            sel_we_s;

   // Tie policy: returns 1 when the data port is to be granted.
`ifdef MEM_ARB_RR_EN
   function automatic logic pick_data(input logic i_e, input logic d_e,
                                      input logic last_d);
      logic pick;
      if (i_e && d_e) begin
         pick = ~last_d;
      end else if (d_e) begin
         pick = 1'b1;
      end else begin
         pick = 1'b0;
      end
      return pick;
   endfunction
`else
   function automatic logic pick_data(input logic i_e, input logic d_e);
      logic pick;
      if (d_e) begin
         pick = 1'b1;
      end else if (i_e) begin
         pick = 1'b0;
      end else begin
         pick = 1'b0;
      end
      return pick;
   endfunction
`endif

   // Eligibility, winner selection and the winner's request fields.
   always_comb begin
      turnaround_s = i_done_r | d_done_r;
      i_elig_s     = i_req & ~turnaround_s;
      d_elig_s     = d_req & ~turnaround_s;
      grant_v_s    = i_elig_s | d_elig_s;
`ifdef MEM_ARB_RR_EN
      grant_d_s    = pick_data(i_elig_s, d_elig_s, last_d_r);
`else
      grant_d_s    = pick_data(i_elig_s, d_elig_s);
`endif
      sel_addr_s   = '0;
      sel_wdata_s  = '0;
      sel_we_s     = 1'b0;
      if (grant_d_s) begin
         sel_addr_s  = d_addr;
         sel_wdata_s = d_wdata;
         sel_we_s    = d_we;
      end else begin
         // The fetch port can only read.
         sel_addr_s  = i_addr;
         sel_wdata_s = '0;
         sel_we_s    = 1'b0;
      end
   end

   // Arbiter FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         addr_r      <= '0;
         wdata_r     <= '0;
         we_r        <= 1'b0;
         port_d_r    <= 1'b0;
         i_done_r    <= 1'b0;
         d_done_r    <= 1'b0;
         rdata_r     <= '0;
         busy_r      <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_d_r    <= 1'b1;
`endif
      end else begin
         // Done pulses last exactly one cycle.
         i_done_r <= 1'b0;
         d_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_v_s) begin
                  addr_r      <= sel_addr_s;
                  wdata_r     <= sel_wdata_s;
                  we_r        <= sel_we_s;
                  port_d_r    <= grant_d_s;
                  mem_read_r  <= ~sel_we_s;
                  mem_write_r <= sel_we_s;
                  busy_r      <= 1'b1;
                  state_r     <= ST_ACCESS;
`ifdef MEM_ARB_RR_EN
                  last_d_r    <= grant_d_s;
`endif
               end else begin
                  mem_read_r  <= 1'b0;
                  mem_write_r <= 1'b0;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               // The strobe is only ever one cycle wide.
               mem_read_r  <= 1'b0;
               mem_write_r <= 1'b0;
               busy_r      <= 1'b1;
               state_r     <= ST_RESP;
            end
            ST_RESP: begin
               // mem_data now holds the word registered by Memory.
               if (!we_r) begin
                  rdata_r <= mem_data;
               end else begin
                  rdata_r <= rdata_r;
               end
               if (port_d_r) begin
                  d_done_r <= 1'b1;
               end else begin
                  i_done_r <= 1'b1;
               end
               mem_read_r  <= 1'b0;
               mem_write_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
            default: begin
               mem_read_r  <= 1'b0;
               mem_write_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign i_done    = i_done_r;
   assign d_done    = d_done_r;
   assign rdata     = rdata_r;
   assign busy      = busy_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign mem_read  = mem_read_r;
   assign mem_write = mem_write_r;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. Contains a 16-word Memory model
// (indexed by the low four address bits, read data registered one edge
// after mem_read), a table of single transactions, hand-written sequences
// for ties, held requests and reset during RESP, and a randomized phase
// compared against a transaction-level reference model.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_done;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_done;
   logic [DW-1:0] rdata;
   logic          busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_data(mem_data)
   );

   // ---------------- Memory model ----------------
   logic [DW-1:0] mem_arr [16];
   logic          preload;

   function automatic logic [31:0] init_word(input int i);
      if (i == 5)      return 32'h0000_1234;
      else if (i == 0) return 32'hDEAD_0000;
      else             return 32'h1000_0000 + 32'(i);
   endfunction

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem_arr[i] <= init_word(i);
      end else if (mem_write) begin
         mem_arr[mem_addr[3:0]] <= mem_wdata;
      end
      if (mem_read) mem_data <= mem_arr[mem_addr[3:0]];
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0; preload = 1'b1;
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1; preload = 1'b0;
   endtask

   typedef struct {
      bit          port_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   // One transaction from the table, started and finished on a negedge.
   task automatic run_vec(input vec_t v, input int idx);
      int lat; int nrd; int nwr; bit got; bit oth; bit bsy;
      logic [31:0] rd; logic [31:0] sa; logic [31:0] sw;
      lat = 0; nrd = 0; nwr = 0; got = 1'b0; oth = 1'b0; bsy = 1'b0;
      rd = '0; sa = '0; sw = '0;
      if (v.port_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      while (!got && lat < 20) begin
         @(posedge clk); @(negedge clk);
         lat++;
         if (mem_read)  nrd++;
         if (mem_write) nwr++;
         if (mem_read || mem_write) begin sa = mem_addr; sw = mem_wdata; end
         if (v.port_d ? d_done : i_done) begin
            got = 1'b1; rd = rdata; bsy = busy;
            oth = v.port_d ? i_done : d_done;
         end
      end
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      chk($sformatf("vec%0d latency", idx), 64'(lat), 64'd3);
      chk($sformatf("vec%0d rdata", idx), 64'(rd), 64'(v.exp_rdata));
      chk($sformatf("vec%0d mem_read count", idx), 64'(nrd), v.we ? 64'd0 : 64'd1);
      chk($sformatf("vec%0d mem_write count", idx), 64'(nwr), v.we ? 64'd1 : 64'd0);
      chk($sformatf("vec%0d mem_addr", idx), 64'(sa), 64'(v.addr));
      if (v.we) chk($sformatf("vec%0d mem_wdata", idx), 64'(sw), 64'(v.wdata));
      chk($sformatf("vec%0d other done", idx), 64'(oth), 64'd0);
      chk($sformatf("vec%0d busy at done", idx), 64'(bsy), 64'd0);
      @(negedge clk);
   endtask

   // ---------------- reference model state (random phase) ----------------
   logic [31:0] ref_mem [16];
   logic [31:0] ref_rdata;
   int          k;
   int          free_at;
   int          g;
   bit          act;
   bit          t_d;
   bit          t_we;
   logic [31:0] t_addr;
   logic [31:0] t_wd;
   logic [31:0] t_rd;
   bit          last_d;

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn_port [4];
      logic [31:0] dn_rd [4];
      int n; int both; int cyc; int ndone_i;
      int tdone [3];
      bit pick_d; bit e_rd; bit e_wr; bit e_bsy; bit e_id; bit e_dd;

      i_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
      i_req = 1'b0; d_req = 1'b0;
      rst_n = 1'b0; preload = 1'b1;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0005, 32'h0,         32'h0000_1234};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0007, 32'h0000_CAFE, 32'h0000_1234};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0007, 32'h0,         32'h0000_CAFE};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0007, 32'h0,         32'h0000_CAFE};
      vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h0000_CAFE};
      vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'hA5A5_A5A5};
      vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hDEAD_0000};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,         32'h0000_1234};

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("reset i_done", 64'(i_done), 64'd0);
      chk("reset d_done", 64'(d_done), 64'd0);
      chk("reset rdata", 64'(rdata), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset mem_read", 64'(mem_read), 64'd0);
      chk("reset mem_write", 64'(mem_write), 64'd0);
      chk("reset mem_addr", 64'(mem_addr), 64'd0);
      chk("reset mem_wdata", 64'(mem_wdata), 64'd0);
      rst_n = 1'b1; preload = 1'b0;

      // ---- table of single transactions ----
      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // ---- tie with both requests held ----
      do_reset(2);
      i_req = 1'b1; i_addr = 32'h0000_0003;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0005;
      n = 0; both = 0; ndone_i = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(posedge clk); @(negedge clk);
         if (i_done && d_done) both++;
         if (i_done) ndone_i++;
         if (i_done || d_done) begin
            dn_port[n] = d_done ? 1 : 0;
            dn_rd[n]   = rdata;
            n++;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      chk("tie done count", 64'(n), 64'd4);
      chk("tie simultaneous done", 64'(both), 64'd0);
      for (int j = 0; j < 4; j++) begin
         if (j < n) begin
`ifdef MEM_ARB_RR_EN
            chk($sformatf("tie grant%0d port", j), 64'(dn_port[j]), (j % 2 == 1) ? 64'd1 : 64'd0);
            chk($sformatf("tie grant%0d rdata", j), 64'(dn_rd[j]),
                (j % 2 == 1) ? 64'h0000_1234 : 64'h1000_0003);
`else
            chk($sformatf("tie grant%0d port", j), 64'(dn_port[j]), 64'd1);
            chk($sformatf("tie grant%0d rdata", j), 64'(dn_rd[j]), 64'h0000_1234);
`endif
         end
      end
`ifndef MEM_ARB_RR_EN
      chk("tie fixed i_done count", 64'(ndone_i), 64'd0);
`endif
      repeat (2) @(negedge clk);

      // ---- fetch request held through i_done ----
      i_req = 1'b1; i_addr = 32'h0000_0005;
      n = 0;
      for (int c = 1; c <= 30 && n < 3; c++) begin
         @(posedge clk); @(negedge clk);
         if (i_done) begin tdone[n] = c; n++; end
      end
      i_req = 1'b0;
      chk("held done count", 64'(n), 64'd3);
      if (n == 3) begin
         chk("held first done cycle", 64'(tdone[0]), 64'd3);
         chk("held period 1", 64'(tdone[1] - tdone[0]), 64'd4);
         chk("held period 2", 64'(tdone[2] - tdone[1]), 64'd4);
      end
      repeat (2) @(negedge clk);

      // ---- reset during RESP ----
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0007;
      @(posedge clk); @(negedge clk);
      chk("rst-resp access mem_read", 64'(mem_read), 64'd1);
      @(posedge clk); @(negedge clk);
      chk("rst-resp in resp busy", 64'(busy), 64'd1);
      chk("rst-resp in resp mem_read", 64'(mem_read), 64'd0);
      rst_n = 1'b0; d_req = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst-resp d_done", 64'(d_done), 64'd0);
      chk("rst-resp i_done", 64'(i_done), 64'd0);
      chk("rst-resp rdata", 64'(rdata), 64'd0);
      chk("rst-resp busy", 64'(busy), 64'd0);
      chk("rst-resp mem_read", 64'(mem_read), 64'd0);
      chk("rst-resp mem_write", 64'(mem_write), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rst-resp late d_done", 64'(d_done), 64'd0);
      chk("rst-resp stays idle", 64'(busy), 64'd0);

      // ---- randomized phase against the reference model ----
      do_reset(2);
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      ref_rdata = '0; k = -1; free_at = 0; act = 1'b0; g = 0;
      t_d = 1'b0; t_we = 1'b0; t_addr = '0; t_wd = '0; t_rd = '0;
      last_d = 1'b1;
      for (cyc = 0; cyc < 800; cyc++) begin
         @(posedge clk);
         k++;
         // Grant rule: arbiter free and someone is asking.
         if (k >= free_at && (i_req || d_req)) begin
            if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
               pick_d = ~last_d;
`else
               pick_d = 1'b1;
`endif
            end else begin
               pick_d = d_req;
            end
            last_d = pick_d;
            act = 1'b1; g = k; free_at = k + 4;
            t_d = pick_d;
            t_we = pick_d ? d_we : 1'b0;
            t_addr = pick_d ? d_addr : i_addr;
            t_wd = d_wdata;
            if (t_we) ref_mem[t_addr % 16] = t_wd;
            else      t_rd = ref_mem[t_addr % 16];
         end
         @(negedge clk);
         e_rd  = act && (k == g) && !t_we;
         e_wr  = act && (k == g) && t_we;
         e_bsy = act && (k == g || k == g + 1);
         e_id  = act && (k == g + 2) && !t_d;
         e_dd  = act && (k == g + 2) && t_d;
         if (act && (k == g + 2) && !t_we) ref_rdata = t_rd;
         chk("rnd mem_read", 64'(mem_read), 64'(e_rd));
         chk("rnd mem_write", 64'(mem_write), 64'(e_wr));
         chk("rnd busy", 64'(busy), 64'(e_bsy));
         chk("rnd i_done", 64'(i_done), 64'(e_id));
         chk("rnd d_done", 64'(d_done), 64'(e_dd));
         chk("rnd rdata", 64'(rdata), 64'(ref_rdata));
         if (e_rd || e_wr) chk("rnd mem_addr", 64'(mem_addr), 64'(t_addr));
         if (e_wr) chk("rnd mem_wdata", 64'(mem_wdata), 64'(t_wd));
         // Requesters: drop on done, otherwise maybe start or wiggle fields.
         if (i_req && i_done) begin
            i_req = 1'b0;
         end else if (!i_req) begin
            if ($urandom_range(0, 3) == 0) begin i_req = 1'b1; i_addr = $urandom; end
         end else if ($urandom_range(0, 3) == 0) begin
            i_addr = $urandom;
         end
         if (d_req && d_done) begin
            d_req = 1'b0;
         end else if (!d_req) begin
            if ($urandom_range(0, 3) == 0) begin
               d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
               d_addr = $urandom; d_wdata = $urandom;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
